// File: rtl/alu_mdu_seq.sv
// ---------------------------------------------------------------------------
// alu_mdu_seq -- sequential ALU with iterative multiply and optional divide
//
// Single-cycle ALU ops (ADD, SUB, XOR, OR, AND, SLT) complete one cycle after
// the start edge. MUL is a shift-add multiplier that takes one step per cycle
// over WIDTH cycles. DIVU/REMU form a restoring divider that produces one
// quotient bit per cycle over WIDTH cycles. Results are registered and held
// until the next done pulse.
//
// Optional feature macro: ALU_MDU_SEQ_DIV_EN
//   defined   -> DIV state and DIVU(7)/REMU(8) datapath are built
//   undefined -> opcodes 7/8 act as reserved (res=0, zero=1, ovf=0)
//
// Parameters:
//   WIDTH    operand/result width (8..64)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   op request, sampled only while busy=0
//   op       in   opcode: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLT,
//                 6 MUL, 7 DIVU, 8 REMU, others reserved
//   a        in   operand A
//   b        in   register operand B
//   imm_ext  in   extended immediate
//   alu_src  in   1 selects imm_ext as B, 0 selects b
//   busy     out  op in progress (MUL, DIV, DONE)
//   done     out  one-cycle result-valid pulse
//   res      out  registered result
//   zero     out  res == 0, registered with res
//   ovf      out  signed overflow for ADD/SUB, else 0
// ---------------------------------------------------------------------------
module alu_mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic             alu_src,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ovf
);

  // Iteration counter runs 0..WIDTH-1.
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_MDU_SEQ_DIV_EN
    S_DIV  = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic add_ovf(input logic xs, input logic ys, input logic ss);
    return (xs == ys) && (ss != xs);
  endfunction

  function automatic logic sub_ovf(input logic xs, input logic ys, input logic ss);
    return (xs != ys) && (ss != xs);
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // opa: multiplicand (MUL) or dividend/quotient shift register (DIV)
  // opb: multiplier (MUL) or divisor (DIV)
  // acc: product accumulator (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] bsel;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic             slt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] mul_acc;

  assign bsel    = alu_src ? imm_ext : b;
  assign sum     = a + bsel;
  assign dif     = a - bsel;
  assign slt     = $signed(a) < $signed(bsel);
  assign mul_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;

`ifdef ALU_MDU_SEQ_DIV_EN
  logic             rem_sel_q, rem_sel_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. With a nonzero divisor the shifted
  // remainder is below 2*divisor, so bit WIDTH of the difference is a clean
  // borrow. A zero divisor always "fits", which naturally yields an all-ones
  // quotient and a remainder equal to A.
  assign rem_sh   = {acc_q, opa_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign div_ge   = ~rem_diff[WIDTH] | (opb_q == '0);
  assign rem_nx   = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx   = {opa_q[WIDTH-2:0], div_ge};
`endif

  // Single-cycle result; reserved codes (and 7/8 without the divider) give 0.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum;
        alu_ovf = add_ovf(a[WIDTH-1], bsel[WIDTH-1], sum[WIDTH-1]);
      end
      4'd1: begin
        alu_res = dif;
        alu_ovf = sub_ovf(a[WIDTH-1], bsel[WIDTH-1], dif[WIDTH-1]);
      end
      4'd2:    alu_res = a ^ bsel;
      4'd3:    alu_res = a | bsel;
      4'd4:    alu_res = a & bsel;
      4'd5:    alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`ifdef ALU_MDU_SEQ_DIV_EN
    rem_sel_d = rem_sel_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            4'd6: begin
              state_d = S_MUL;
              opa_d   = a;
              opb_d   = bsel;
              acc_d   = '0;
              cnt_d   = '0;
            end
`ifdef ALU_MDU_SEQ_DIV_EN
            4'd7, 4'd8: begin
              state_d   = S_DIV;
              opa_d     = a;
              opb_d     = bsel;
              acc_d     = '0;
              cnt_d     = '0;
              rem_sel_d = (op == 4'd8);
            end
`endif
            default: begin
              state_d = S_DONE;
              res_d   = alu_res;
              zero_d  = (alu_res == '0);
              ovf_d   = alu_ovf;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          res_d   = mul_acc;
          zero_d  = (mul_acc == '0);
          ovf_d   = 1'b0;
        end
      end
`ifdef ALU_MDU_SEQ_DIV_EN
      S_DIV: begin
        acc_d = rem_nx;
        opa_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          res_d   = rem_sel_q ? rem_nx : quo_nx;
          zero_d  = rem_sel_q ? (rem_nx == '0) : (quo_nx == '0);
          ovf_d   = 1'b0;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ALU_MDU_SEQ_DIV_EN
      rem_sel_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`ifdef ALU_MDU_SEQ_DIV_EN
      rem_sel_q <= rem_sel_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign res  = res_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu_seq -- self-checking bench for alu_mdu_seq (WIDTH=32)
//
// A behavioural model computes each op's result with plain arithmetic and
// releases it after the op's latency; a compare process checks busy, done,
// res, zero and ovf against the model on every falling edge. Directed
// vectors additionally pin hand-computed literal results and latencies.
// ---------------------------------------------------------------------------
module tb_alu_mdu_seq;

  localparam int     W    = 32;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b1;
  logic         start   = 1'b0;
  logic         alu_src = 1'b0;
  logic [3:0]   op      = 4'd0;
  logic [W-1:0] a       = '0;
  logic [W-1:0] b       = '0;
  logic [W-1:0] imm_ext = '0;
  logic         busy, done, zero, ovf;
  logic [W-1:0] res;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_mdu_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .imm_ext (imm_ext),
    .alu_src (alu_src),
    .busy    (busy),
    .done    (done),
    .res     (res),
    .zero    (zero),
    .ovf     (ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int model_lat(input logic [3:0] o);
    if (o == 4'd6) return W + 1;
`ifdef ALU_MDU_SEQ_DIV_EN
    if (o == 4'd7 || o == 4'd8) return W + 1;
`endif
    return 1;
  endfunction

  // Returns {ovf, res}.
  function automatic logic [W:0] model_op(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    longint          sx, sy, t;
    longint unsigned ux, uy, p;
    logic [W-1:0]    r;
    logic            v;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    r  = '0;
    v  = 1'b0;
    case (o)
      4'd0: begin t = sx + sy; r = t[W-1:0]; v = (t > MAXS) || (t < MINS); end
      4'd1: begin t = sx - sy; r = t[W-1:0]; v = (t > MAXS) || (t < MINS); end
      4'd2: r = x ^ y;
      4'd3: r = x | y;
      4'd4: r = x & y;
      4'd5: r = {{(W-1){1'b0}}, (sx < sy)};
      4'd6: begin p = ux * uy; r = p[W-1:0]; end
`ifdef ALU_MDU_SEQ_DIV_EN
      4'd7: r = (y == '0) ? '1 : x / y;
      4'd8: r = (y == '0) ? x : x % y;
`endif
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  bit           m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_res  = '0;
  logic [W-1:0] p_res  = '0;
  logic         p_ovf  = 1'b0;
  int           m_wait = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_zero = 1'b0; m_ovf = 1'b0; m_wait = 0;
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin
        m_done = 1'b1; m_res = p_res; m_zero = (p_res == '0); m_ovf = p_ovf;
      end
    end else if (start) begin
      {p_ovf, p_res} = model_op(op, a, alu_src ? imm_ext : b);
      m_busy = 1'b1;
      m_wait = model_lat(op) - 1;
      if (m_wait == 0) begin
        m_done = 1'b1; m_res = p_res; m_zero = (p_res == '0); m_ovf = p_ovf;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_res",  res,  m_res);
      chk("cyc_zero", zero, m_zero);
      chk("cyc_ovf",  ovf,  m_ovf);
    end
  end

  // ---------------- driver ----------------
  // Waits for idle, issues one op, scrambles inputs after the start edge and
  // optionally pokes start while busy. Returns with done high; lat counts
  // the start edge as 1.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] im, input logic src, input bit poke,
                        output int lat);
    int guard;
    guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    op = o; a = x; b = y; imm_ext = im; alu_src = src; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; imm_ext = $urandom;
    op = 4'd0; alu_src = ~src;
    lat = 1;
    while (!done && lat < 200) begin
      start = poke && (lat % 5 == 2);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: actual no done required done within 200 cycles");
    end
  endtask

  initial begin
    int lat;
    int c0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res",  res,  0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf",  ovf,  0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, lat);
    chk("add_ovf_lat", lat, 1);
    chk("add_ovf_res", res, 32'h8000_0000);
    chk("add_ovf_ovf", ovf, 1);
    chk("add_ovf_zero", zero, 0);

    run_op(4'd1, 32'd5, 32'd9, 32'd5, 1'b1, 1'b0, lat);
    chk("sub_imm_res", res, 0);
    chk("sub_imm_zero", zero, 1);
    chk("sub_imm_ovf", ovf, 0);

    run_op(4'd1, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 1'b0, lat);
    chk("sub_ovf_res", res, 32'h7FFF_FFFF);
    chk("sub_ovf_ovf", ovf, 1);

    run_op(4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, lat);
    chk("add_wrap_res", res, 0);
    chk("add_wrap_ovf", ovf, 0);

    run_op(4'd2, 32'hF0F0_F0F0, 32'h0000_1234, 32'hFF00_FF00, 1'b1, 1'b0, lat);
    chk("xor_res", res, 32'h0FF0_0FF0);
    run_op(4'd3, 32'h1234_0000, 32'h0000_5678, 32'h0, 1'b0, 1'b0, lat);
    chk("or_res", res, 32'h1234_5678);
    run_op(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 1'b0, 1'b0, lat);
    chk("and_res", res, 32'h0F0F_0000);

    run_op(4'd5, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, lat);
    chk("slt_neg_res", res, 1);
    c0 = cyc;
    run_op(4'd0, 32'd10, 32'd20, 32'h0, 1'b0, 1'b0, lat);
    chk("b2b_res", res, 30);
    chk("b2b_lat", lat, 1);
    chk("b2b_gap", cyc - c0, 2);
    run_op(4'd5, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, lat);
    chk("slt_pos_res", res, 0);
    chk("slt_pos_zero", zero, 1);

    run_op(4'd6, 32'h0001_0000, 32'h0001_0001, 32'h0, 1'b0, 1'b1, lat);
    chk("mul_lat", lat, 33);
    chk("mul_res", res, 32'h0001_0000);
    run_op(4'd6, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
    chk("mul_ones_res", res, 1);
    run_op(4'd6, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, lat);
    chk("mul_zero_zero", zero, 1);

`ifdef ALU_MDU_SEQ_DIV_EN
    run_op(4'd7, 32'd100, 32'd7, 32'h0, 1'b0, 1'b1, lat);
    chk("divu_lat", lat, 33);
    chk("divu_res", res, 14);
    run_op(4'd8, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, lat);
    chk("remu_res", res, 2);
    run_op(4'd7, 32'd100, 32'd0, 32'h0, 1'b0, 1'b0, lat);
    chk("divu_by0_res", res, 32'hFFFF_FFFF);
    chk("divu_by0_lat", lat, 33);
    run_op(4'd8, 32'hDEAD, 32'd0, 32'h0, 1'b0, 1'b0, lat);
    chk("remu_by0_res", res, 32'hDEAD);
`else
    run_op(4'd7, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, lat);
    chk("divu_off_lat", lat, 1);
    chk("divu_off_res", res, 0);
    chk("divu_off_zero", zero, 1);
    run_op(4'd8, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, lat);
    chk("remu_off_res", res, 0);
    chk("remu_off_zero", zero, 1);
`endif

    run_op(4'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, lat);
    run_op(4'd9, 32'd5, 32'd5, 32'h0, 1'b0, 1'b0, lat);
    chk("rsvd_lat", lat, 1);
    chk("rsvd_res", res, 0);
    chk("rsvd_zero", zero, 1);
    chk("rsvd_ovf", ovf, 0);
    run_op(4'd15, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, lat);
    chk("rsvd15_res", res, 0);

    run_op(4'd0, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, lat);
    chk("pre_rst_res", res, 2);

    // Abort a multiply part-way through with an asynchronous reset.
    @(posedge clk); #1;
    op = 4'd6; a = 32'h1234; b = 32'h5678; alu_src = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res",  res,  0);
    chk("abort_zero", zero, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_nodone", done, 0);

    run_op(4'd0, 32'd2, 32'd3, 32'h0, 1'b0, 1'b0, lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_res", res, 5);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
ALU_MDU_SEQ -- requirements
Module: alu_mdu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  op request, sampled only when busy=0.
REQ-005 SHALL have port op  input  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLT (signed), 6 MUL (low WIDTH bits), 7 DIVU, 8 REMU, others reserved.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  register operand B.
REQ-008 SHALL have port imm_ext  input  WIDTH  extended immediate.
REQ-009 SHALL have port alu_src  input  1  1 selects imm_ext as B, 0 selects b.
REQ-010 SHALL have port busy  output  1  op in progress.
REQ-011 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have port res  output  WIDTH  registered result.
REQ-013 SHALL have port zero  output  1  res == 0, registered with res.
REQ-014 SHALL have port ovf  output  1  signed overflow for ADD/SUB, else 0.

Function
REQ-015 SHALL capture a, selected B and op on the edge where start=1 and busy=0; later input changes SHALL not affect that op.
REQ-016 SHALL ignore start while busy=1 (no queueing, no error).
REQ-017 SHALL implement states IDLE, MUL, DIV, DONE; IDLE->DONE for ops 0-5 and reserved, IDLE->MUL for 6, IDLE->DIV for 7/8, MUL/DIV->DONE after WIDTH iteration cycles, DONE->IDLE unconditionally.
REQ-018 SHALL assert busy in MUL, DIV and DONE, deassert in IDLE; a new start SHALL be accepted the cycle after done.
REQ-019 SHALL assert done for exactly one cycle, in DONE; ops 0-5 latency 1 cycle after start edge, MUL/DIV latency WIDTH+1 cycles.
REQ-020 SHALL hold res, zero, ovf stable from done until the next done.
REQ-021 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf SHALL follow two's-complement sign rules.
REQ-022 SLT SHALL return 1 if signed A < signed B, else 0.
REQ-023 MUL SHALL use one shift-add step per cycle, returning the low WIDTH bits of the unsigned product.
REQ-024 DIVU/REMU SHALL use restoring division, one quotient bit per cycle.
REQ-025 Division by zero SHALL return quotient all-ones and remainder = A, same latency.
REQ-026 Reserved opcodes SHALL return res=0, zero=1, ovf=0 with 1-cycle latency.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, busy=0, done=0, res=0, zero=0, ovf=0, clearing iteration counter and partial results.
REQ-028 Reset mid-MUL/DIV SHALL abort the op with no done pulse; first start after rst_n rises SHALL be processed normally.

Configuration
REQ-029 Macro ALU_MDU_SEQ_DIV_EN defined SHALL compile in the DIV state and DIVU/REMU datapath.
REQ-030 Without ALU_MDU_SEQ_DIV_EN, opcodes 7/8 SHALL behave as reserved (REQ-026) and no divider logic SHALL exist.

Verification (WIDTH=32)
REQ-031 ADD a=0x7FFFFFFF, b=1, alu_src=0 -> done 1 cycle later, res=0x80000000, ovf=1, zero=0.
REQ-032 SUB alu_src=1, a=5, imm_ext=5, b=9 -> res=0, zero=1, ovf=0.
REQ-033 MUL a=0x00010000, b=0x00010001 -> done 33 cycles after start, res=0x00010000; start pulses while busy ignored.
REQ-034 DIVU a=100, b=7 -> res=14; REMU -> res=2; DIVU b=0 -> res=0xFFFFFFFF; without macro both -> res=0, zero=1.
REQ-035 rst_n low at cycle 10 of MUL -> busy=0, res=0 at once, no done; next ADD 2+3 -> res=5.
REQ-036 SLT a=0xFFFFFFFF, b=1 -> res=1; back-to-back start in cycle after done -> accepted.
